// File: rtl/arm_pipe_pkg.sv
// Shared constants and types for the pipeline stage chain.
// The slot control struct is the only interface between the chain and its slots.
package arm_pipe_pkg;

    localparam int DefaultWidth = 32;
    localparam int DefaultDepth = 4;

    typedef struct packed {
        logic load;
        logic drop;
    } slotCtrl_t;

    // Bits needed to count 0..depth valid stages.
    function automatic int occWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: a valid bit plus a payload register.
// Load wins over drop; with neither asserted the slot holds its contents.
module pipe_stage_slot
    import arm_pipe_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  slotCtrl_t        ctrl,
    input  logic [WIDTH-1:0] loadData,
    output logic             valid,
    output logic [WIDTH-1:0] payload
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (ctrl.load) begin
            valid   <= 1'b1;
            payload <= loadData;
        end else if (ctrl.drop) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline of DEPTH slots with bubble collapse, global stall and per-stage flush.
// The advance chain is resolved from the last stage backward, so in_valid never reaches out_valid.
module pipe_stage_chain
    import arm_pipe_pkg::*;
#(
    parameter int WIDTH = DefaultWidth,
    parameter int DEPTH = DefaultDepth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic                         stall,
    input  logic [DEPTH-1:0]             flush_mask,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [occWidth(DEPTH)-1:0]   occupancy
);

    localparam int OccW = occWidth(DEPTH);
    localparam logic [OccW-1:0] OccOne = OccW'(1);

    logic [DEPTH-1:0] advance;
    logic [DEPTH-1:0] loadVec;
    logic [DEPTH-1:0] dropVec;
    logic [DEPTH-1:0] killedValid;
    logic [WIDTH-1:0] payload [DEPTH];
    logic             headRoom;
    logic             accept;
    logic             deliver;
    logic [OccW-1:0]  occNext;

    // room carries "the slot ahead is free or vacating" one stage further back each iteration.
    always_comb begin
        logic room;
        logic go;
        advance = '0;
        room    = out_ready;
        go      = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            go         = stage_valid[i] && !flush_mask[i] && !stall && room;
            advance[i] = go;
            room       = !stage_valid[i] || go;
        end
        headRoom = room;
    end

    assign in_ready  = rst && !stall && (flush_mask == '0) && headRoom;
    assign out_valid = rst && stage_valid[DEPTH-1] && !flush_mask[DEPTH-1] && !stall;
    assign out_data  = payload[DEPTH-1];

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    assign loadVec     = {advance[DEPTH-2:0], accept};
    assign dropVec     = flush_mask | advance;
    assign killedValid = stage_valid & flush_mask;

    for (genvar i = 0; i < DEPTH; i++) begin : gSlot
        logic [WIDTH-1:0] feed;
        slotCtrl_t        ctrl;

        if (i == 0) begin : gHead
            assign feed = in_data;
        end else begin : gBody
            assign feed = payload[i-1];
        end

        assign ctrl = '{load: loadVec[i], drop: dropVec[i]};

        pipe_stage_slot #(
            .WIDTH(WIDTH)
        ) uSlot (
            .clk      (clk),
            .rst      (rst),
            .ctrl     (ctrl),
            .loadData (feed),
            .valid    (stage_valid[i]),
            .payload  (payload[i])
        );
    end

    // A delivered stage is never a killed one, so the running value stays within 0..DEPTH.
    always_comb begin
        occNext = occupancy;
        if (accept) begin
            occNext = occNext + OccOne;
        end
        if (deliver) begin
            occNext = occNext - OccOne;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (killedValid[i]) begin
                occNext = occNext - OccOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occNext;
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus randomized traffic against an entry-list model.
module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         stall = 1'b0;
    logic [D-1:0] flush_mask = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [D-1:0] stage_valid;
    logic [2:0]   occupancy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stall       (stall),
        .flush_mask  (flush_mask),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    // Model: list of live entries, oldest first, each with its stage position.
    int           mPos[$];
    logic [W-1:0] mData[$];

    logic         expInReady, expOutValid;
    logic [W-1:0] expOutData;
    logic [D-1:0] expStageValid;
    int           expOcc;
    logic         obsInReady, obsOutValid;
    logic [W-1:0] obsOutData;

    task automatic model_step(input logic inv, input logic [W-1:0] din, input logic ordy,
                              input logic stl, input logic [D-1:0] fm);
        int           nPos[$];
        logic [W-1:0] nData[$];
        int           prevPos;
        logic         prevMoved, moved, headFree;
        prevPos = -1;
        prevMoved = 1'b0;
        headFree = 1'b1;
        expOutValid = 1'b0;
        expOutData = '0;
        if (mPos.size() > 0 && mPos[0] == D - 1) begin
            expOutValid = !fm[D-1] && !stl;
            expOutData = mData[0];
        end
        foreach (mPos[k]) begin
            int p;
            p = mPos[k];
            // An entry moves if not frozen/killed and the position ahead was free or its occupant moved.
            moved = !stl && !fm[p] && ((p == D - 1) ? ordy : (prevPos != p + 1 || prevMoved));
            if (p == 0) headFree = moved;
            if (!fm[p] && !(p == D - 1 && moved)) begin
                nPos.push_back(moved ? p + 1 : p);
                nData.push_back(mData[k]);
            end
            prevPos = p;
            prevMoved = moved;
        end
        expInReady = !stl && (fm == '0) && headFree;
        if (inv && expInReady) begin
            nPos.push_back(0);
            nData.push_back(din);
        end
        mPos = nPos;
        mData = nData;
        expOcc = mPos.size();
        expStageValid = '0;
        foreach (mPos[k]) expStageValid[mPos[k]] = 1'b1;
    endtask

    // Drives one cycle: inputs set, combinational outputs sampled, edge taken, returns at edge+1.
    task automatic step(input logic inv, input logic [W-1:0] din, input logic ordy,
                        input logic stl, input logic [D-1:0] fm);
        in_valid = inv;
        in_data = din;
        out_ready = ordy;
        stall = stl;
        flush_mask = fm;
        #1;
        obsInReady = in_ready;
        obsOutValid = out_valid;
        obsOutData = out_data;
        model_step(inv, din, ordy, stl, fm);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (stage_valid !== 4'b0000) begin bad++; $display("FAIL reset_stage_valid got %b want 0000", stage_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency();
        logic [W-1:0] pushData[3];
        logic         wantValid[7];
        logic [W-1:0] wantData[7];
        pushData = '{32'hA1, 32'hA2, 32'hA3};
        wantValid = '{0, 0, 0, 0, 1, 1, 1};
        wantData = '{0, 0, 0, 0, 32'hA1, 32'hA2, 32'hA3};
        for (int s = 0; s < 7; s++) begin
            step(s < 3, (s < 3) ? pushData[s] : '0, 1'b1, 1'b0, '0);
            total++;
            if (obsOutValid !== wantValid[s]) begin
                bad++; $display("FAIL latency_out_valid step %0d got %b want %b", s, obsOutValid, wantValid[s]);
            end
            if (wantValid[s]) begin
                total++;
                if (obsOutData !== wantData[s]) begin
                    bad++; $display("FAIL latency_out_data step %0d got %h want %h", s, obsOutData, wantData[s]);
                end
            end
            if (s < 3) begin
                total++;
                if (obsInReady !== 1'b1) begin bad++; $display("FAIL latency_in_ready step %0d got %b want 1", s, obsInReady); end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int s = 0; s < 5; s++) begin
            step(1'b1, 32'hB0 + W'(s), 1'b0, 1'b0, '0);
            total++;
            if (obsInReady !== (s < 4)) begin
                bad++; $display("FAIL bp_in_ready push %0d got %b want %b", s, obsInReady, s < 4);
            end
        end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_full_occupancy got %0d want 4", occupancy); end
        for (int s = 0; s < 4; s++) begin
            step(1'b0, '0, 1'b1, 1'b0, '0);
            total++;
            if (obsOutValid !== 1'b1 || obsOutData !== 32'hB0 + W'(s)) begin
                bad++; $display("FAIL bp_drain_data %0d got v=%b d=%h want v=1 d=%h", s, obsOutValid, obsOutData, 32'hB0 + W'(s));
            end
            total++;
            if (occupancy !== 3'(3 - s)) begin
                bad++; $display("FAIL bp_drain_occupancy %0d got %0d want %0d", s, occupancy, 3 - s);
            end
        end
    endtask

    task automatic test_flush();
        int delivered;
        step(1'b1, 32'h11, 1'b0, 1'b0, '0);
        step(1'b1, 32'h10, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        total++; if (stage_valid !== 4'b0110 || occupancy !== 3'd2) begin
            bad++; $display("FAIL flush_setup got sv=%b occ=%0d want sv=0110 occ=2", stage_valid, occupancy);
        end
        step(1'b0, '0, 1'b1, 1'b0, 4'b0100);
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL flush_occupancy got %0d want 1", occupancy); end
        total++; if (stage_valid !== 4'b0010) begin bad++; $display("FAIL flush_stage_valid got %b want 0010", stage_valid); end
        delivered = 0;
        for (int s = 0; s < 5; s++) begin
            step(1'b0, '0, 1'b1, 1'b0, '0);
            if (obsOutValid === 1'b1) begin
                delivered++;
                total++;
                if (obsOutData !== 32'h10) begin bad++; $display("FAIL flush_survivor got %h want 10", obsOutData); end
            end
        end
        total++; if (delivered != 1) begin bad++; $display("FAIL flush_delivery_count got %0d want 1", delivered); end
    endtask

    task automatic test_stall();
        for (int s = 0; s < 4; s++) step(1'b1, 32'hC0 + W'(s), 1'b0, 1'b0, '0);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 32'hEE, 1'b1, 1'b1, '0);
            total++;
            if (obsOutValid !== 1'b0 || obsInReady !== 1'b0) begin
                bad++; $display("FAIL stall_handshake cycle %0d got ov=%b ir=%b want 0 0", s, obsOutValid, obsInReady);
            end
            total++;
            if (stage_valid !== 4'b1111) begin bad++; $display("FAIL stall_stage_valid cycle %0d got %b want 1111", s, stage_valid); end
        end
        for (int s = 0; s < 4; s++) begin
            step(1'b0, '0, 1'b1, 1'b0, '0);
            total++;
            if (obsOutValid !== 1'b1 || obsOutData !== 32'hC0 + W'(s)) begin
                bad++; $display("FAIL stall_resume %0d got v=%b d=%h want v=1 d=%h", s, obsOutValid, obsOutData, 32'hC0 + W'(s));
            end
        end
    endtask

    task automatic test_stall_flush();
        for (int s = 0; s < 3; s++) step(1'b1, 32'hD0 + W'(s), 1'b0, 1'b0, '0);
        step(1'b1, 32'hDD, 1'b1, 1'b1, 4'b1111);
        total++; if (obsInReady !== 1'b0) begin bad++; $display("FAIL stallflush_in_ready got %b want 0", obsInReady); end
        total++; if (stage_valid !== 4'b0000 || occupancy !== 3'd0) begin
            bad++; $display("FAIL stallflush_cleared got sv=%b occ=%0d want 0000 0", stage_valid, occupancy);
        end
    endtask

    task automatic test_async_reset();
        for (int s = 0; s < 3; s++) step(1'b1, 32'hE0 + W'(s), 1'b0, 1'b0, '0);
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL areset_pre_occupancy got %0d want 3", occupancy); end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        mPos.delete();
        mData.delete();
        total++; if (stage_valid !== 4'b0000 || occupancy !== 3'd0) begin
            bad++; $display("FAIL areset_immediate got sv=%b occ=%0d want 0000 0", stage_valid, occupancy);
        end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL areset_handshake got ov=%b ir=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step(1'b0, '0, 1'b1, 1'b0, '0);
            total++;
            if (obsOutValid !== 1'b0) begin bad++; $display("FAIL areset_no_delivery cycle %0d got %b want 0", s, obsOutValid); end
        end
        step(1'b1, 32'hF1, 1'b1, 1'b0, '0);
        total++; if (obsInReady !== 1'b1 || occupancy !== 3'd1) begin
            bad++; $display("FAIL areset_first_accept got ir=%b occ=%0d want 1 1", obsInReady, occupancy);
        end
    endtask

    task automatic test_random();
        logic         inv, ordy, stl;
        logic [D-1:0] fm;
        logic [W-1:0] din;
        for (int c = 0; c < 600; c++) begin
            inv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            stl = ($urandom_range(0, 7) == 0);
            fm = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            din = $urandom;
            step(inv, din, ordy, stl, fm);
            total++;
            if (obsInReady !== expInReady) begin
                bad++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", c, obsInReady, expInReady);
            end
            total++;
            if (obsOutValid !== expOutValid) begin
                bad++; $display("FAIL rnd_out_valid cycle %0d got %b want %b", c, obsOutValid, expOutValid);
            end
            if (expOutValid) begin
                total++;
                if (obsOutData !== expOutData) begin
                    bad++; $display("FAIL rnd_out_data cycle %0d got %h want %h", c, obsOutData, expOutData);
                end
            end
            total++;
            if (stage_valid !== expStageValid) begin
                bad++; $display("FAIL rnd_stage_valid cycle %0d got %b want %b", c, stage_valid, expStageValid);
            end
            total++;
            if (occupancy !== 3'(expOcc)) begin
                bad++; $display("FAIL rnd_occupancy cycle %0d got %0d want %0d", c, occupancy, expOcc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_flush();
        test_stall();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
